// File: rtl/nibble_serial_adder_if.sv
// Handshake and adder-facing signal bundle for nibble_serial_adder.
// slave is the controller side; master is the environment (producer, consumer and 4-bit adder).
interface nibble_serial_adder_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder that reuses an external combinational 4-bit adder,
// one nibble per clock, least-significant nibble first.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q;
    logic [W-1:0]      a_q, b_q, sum_q;
    logic              carry_q, cout_q;
    logic [W-1:0]      a_sh, b_sh;
    logic              last;

    assign last = (idx_q == IdxW'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic; the adder inputs are parked at zero outside RUN
    always_comb begin
        a_sh          = a_q >> {idx_q, 2'b00};
        b_sh          = b_q >> {idx_q, 2'b00};
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.add_a     = 4'd0;
        bus.add_b     = 4'd0;
        bus.add_cin   = 1'b0;
        if (state_q == StRun) begin
            bus.add_a   = a_sh[3:0];
            bus.add_b   = b_sh[3:0];
            bus.add_cin = carry_q;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    // Operand, carry chain and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_b;
                        carry_q <= bus.op_cin;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    for (int i = 0; i < int'(NIBBLES); i++) begin
                        if (idx_q == IdxW'(i)) sum_q[4*i +: 4] <= bus.add_s;
                    end
                    carry_q <= bus.add_cout;
                    if (last) begin
                        cout_q <= bus.add_cout;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised self-checking bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1 builds).
module tb_nibble_serial_adder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    nibble_serial_adder_if #(.NIBBLES(4)) bus4();
    nibble_serial_adder_if #(.NIBBLES(1)) bus1();

    nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // The lab's combinational 4-bit adder, one per instance
    assign {bus4.add_cout, bus4.add_s} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {4'd0, bus4.add_cin};
    assign {bus1.add_cout, bus1.add_s} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'd0, bus1.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry entering nibble k of a+b+cin
    function automatic logic ref_carry(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input int k);
        logic [16:0] mask, t;
        mask = (17'd1 << (4 * k)) - 17'd1;
        t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, cin};
        return t[4*k];
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int hold);
        logic [16:0] exp;
        logic [3:0]  na, nb;
        exp = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            errors++; $display("FAIL in_ready_idle got=%b want=1", bus4.in_ready);
        end
        bus4.in_valid = 1'b1; bus4.op_a = a; bus4.op_b = b; bus4.op_cin = cin;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0; bus4.op_a = 16'($urandom); bus4.op_b = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            na = 4'((a >> (4 * k)) & 16'hF);
            nb = 4'((b >> (4 * k)) & 16'hF);
            checks++;
            if (bus4.add_a !== na || bus4.add_b !== nb) begin
                errors++; $display("FAIL run_nibble k=%0d got a=%h b=%h want a=%h b=%h",
                                   k, bus4.add_a, bus4.add_b, na, nb);
            end
            checks++;
            if (bus4.add_cin !== ref_carry(a, b, cin, k)) begin
                errors++; $display("FAIL run_cin k=%0d got=%b want=%b", k, bus4.add_cin,
                                   ref_carry(a, b, cin, k));
            end
            checks++;
            if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b0) begin
                errors++; $display("FAIL run_flags k=%0d got out_valid=%b in_ready=%b want 0 0",
                                   k, bus4.out_valid, bus4.in_ready);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.sum !== exp[15:0] || bus4.cout !== exp[16]) begin
            errors++; $display("FAIL result a=%h b=%h cin=%b got v=%b sum=%h cout=%b want 1 %h %b",
                               a, b, cin, bus4.out_valid, bus4.sum, bus4.cout, exp[15:0], exp[16]);
        end
        for (int h = 0; h < hold; h++) begin
            bus4.in_valid = 1'b1; bus4.op_a = 16'($urandom); bus4.op_b = 16'($urandom);
            bus4.op_cin = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0 ||
                bus4.sum !== exp[15:0] || bus4.cout !== exp[16]) begin
                errors++; $display("FAIL backpressure h=%0d got v=%b rdy=%b sum=%h cout=%b want 1 0 %h %b",
                                   h, bus4.out_valid, bus4.in_ready, bus4.sum, bus4.cout,
                                   exp[15:0], exp[16]);
            end
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.sum !== exp[15:0]) begin
            errors++; $display("FAIL release got v=%b rdy=%b sum=%h want 0 1 %h",
                               bus4.out_valid, bus4.in_ready, bus4.sum, exp[15:0]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.sum !== 16'h0 ||
            bus4.cout !== 1'b0 || bus4.add_a !== 4'h0 || bus4.add_b !== 4'h0 ||
            bus4.add_cin !== 1'b0) begin
            errors++; $display("FAIL reset got rdy=%b v=%b sum=%h cout=%b a=%h b=%h cin=%b",
                               bus4.in_ready, bus4.out_valid, bus4.sum, bus4.cout,
                               bus4.add_a, bus4.add_b, bus4.add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        run_op(16'h0006, 16'h0003, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h12C0, 16'h0350, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 20; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
        end
    endtask

    task automatic test_backpressure;
        run_op(16'hBEEF, 16'h1234, 1'b1, 5);
        run_op(16'($urandom), 16'($urandom), 1'($urandom), 3);
    endtask

    task automatic test_reset_mid_run;
        bus4.in_valid = 1'b1; bus4.op_a = 16'hABCD; bus4.op_b = 16'h1111; bus4.op_cin = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.sum !== 16'h0 ||
            bus4.cout !== 1'b0 || bus4.add_a !== 4'h0 || bus4.add_b !== 4'h0 ||
            bus4.add_cin !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run got rdy=%b v=%b sum=%h cout=%b a=%h b=%h cin=%b",
                               bus4.in_ready, bus4.out_valid, bus4.sum, bus4.cout,
                               bus4.add_a, bus4.add_b, bus4.add_cin);
        end
        repeat (4) begin
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b0 || bus4.sum !== 16'h0) begin
                errors++; $display("FAIL reset_hold got v=%b sum=%h want 0 0000",
                                   bus4.out_valid, bus4.sum);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0012, 16'h0005, 1'b0, 0);
    endtask

    task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        bus1.in_valid = 1'b1; bus1.op_a = a; bus1.op_b = b; bus1.op_cin = cin;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        checks++;
        if (bus1.add_a !== a || bus1.add_b !== b || bus1.add_cin !== cin ||
            bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL n1_run got a=%h b=%h cin=%b v=%b want %h %h %b 0",
                               bus1.add_a, bus1.add_b, bus1.add_cin, bus1.out_valid, a, b, cin);
        end
        @(posedge clk); #1;
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.sum !== exp[3:0] || bus1.cout !== exp[4]) begin
            errors++; $display("FAIL n1_result got v=%b sum=%h cout=%b want 1 %h %b",
                               bus1.out_valid, bus1.sum, bus1.cout, exp[3:0], exp[4]);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL n1_release got rdy=%b v=%b want 1 0",
                               bus1.in_ready, bus1.out_valid);
        end
    endtask

    task automatic test_single_nibble;
        run_op1(4'd12, 4'd5, 1'b1);
        for (int n = 0; n < 8; n++) begin
            run_op1(4'($urandom), 4'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_cin = 1'b0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        test_single_nibble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential controller that adds two NIBBLES×4-bit operands by time-multiplexing the lab's existing combinational 4-bit adder (ports a, b, cin → s, cout), one nibble per clock, least-significant first. It sits directly upstream and downstream of that adder. It drives the adder's a/b/cin from registered operand nibbles, captures s/cout back, and chains cout into the next cin. Operands arrive via a valid/ready handshake, and the full sum leaves via a second valid/ready handshake.

## Interface
- NIBBLES, 4, number of 4-bit digits per operand; operand width W = 4×NIBBLES; legal range 1..8.

- clk  in  1  single clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands; equals (state == IDLE).
- op_a  in  W  operand A, sampled on the in handshake.
- op_b  in  W  operand B, sampled on the in handshake.
- op_cin  in  1  initial carry-in, sampled on the in handshake.
- add_a  out  4  nibble of A presented to the 4-bit adder.
- add_b  out  4  nibble of B presented to the 4-bit adder.
- add_cin  out  1  carry presented to the 4-bit adder.
- add_s  in  4  adder sum nibble; combinational and valid in the same cycle.
- add_cout  in  1  adder carry out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result, {nibble NIBBLES-1 … nibble 0}.
- cout  out  1  final carry out of the top nibble.

## Operation
- FSM with three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register op_a, op_b; set carry_reg←op_cin; set idx←0; go to RUN.
- RUN:
  - add_a = A_reg[4·idx+3:4·idx], add_b = B_reg[4·idx+3:4·idx], add_cin = carry_reg.
  - Each edge: sum[4·idx+3:4·idx]←add_s, carry_reg←add_cout.
  - If idx==NIBBLES-1: cout←add_cout and go to DONE; else idx←idx+1.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready go to IDLE.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- in_valid is ignored outside IDLE. No operand queueing: an in handshake in the same cycle as the out handshake is not possible, since in_ready=0 in DONE.
- sum and cout keep the last result in IDLE until the next RUN overwrites them nibble by nibble. They are guaranteed only while out_valid=1.
- Arithmetic is unsigned modulo 2^W; cout is bit W of A+B+cin.
- Internal width rules:
  - idx is ceil(log2(NIBBLES)) bits, minimum 1.
  - A_reg and B_reg are W bits.
  - No sign extension.

## Timing
- Reset (rst_n low, asynchronous), applies immediately:
  - state=IDLE.
  - in_ready=1 (combinational from state).
  - out_valid=0, sum=0, cout=0, idx=0, carry_reg=0, A_reg=B_reg=0.
  - add_a=add_b=0, add_cin=0.
- Release is synchronous to clk. The bench deasserts rst_n away from the rising edge.
- Latency: in handshake at edge E0. RUN occupies cycles E0+1 … E0+NIBBLES. out_valid rises after edge E0+NIBBLES, i.e. NIBBLES cycles after acceptance.
- Earliest next acceptance is one cycle after the out handshake, giving a throughput of one sum per NIBBLES+2 cycles with out_ready held high.
- Backpressure: with out_ready=0, the block stays in DONE indefinitely and out_valid, sum, cout are constant.
- Reset mid-RUN or mid-DONE aborts the operation; all outputs take their reset values at once and the partial sum is discarded.
- Carry propagation through every nibble (e.g. 0xFFFF+1) takes exactly NIBBLES cycles, with no extra cycles.
- With NIBBLES=1: a single RUN cycle, and out_valid one cycle after acceptance.

## Test plan
- Reset: assert rst_n=0 mid-cycle → in_ready=1, out_valid=0, sum=0x0000, cout=0, add_a=add_b=0, without waiting for a clock edge.
- Basic add (NIBBLES=4, adder connected): op_a=0x0006, op_b=0x0003, op_cin=0 → out_valid 4 cycles after acceptance; sum=0x0009, cout=0. During RUN, add_a sequence is 6,0,0,0.
- Full ripple: op_a=0xFFFF, op_b=0x0001, op_cin=0 → sum=0x0000, cout=1. add_cin sequence is 0,1,1,1.
- Carry-in with mixed nibbles: op_a=0x12C0, op_b=0x0350, op_cin=1 → sum=0x1611, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with new operands → out_valid stays 1, sum and cout unchanged, in_ready=0, new operands not captured. Raising out_ready returns the block to IDLE one edge later.
- Reset mid-RUN, then NIBBLES=1 build:
  - Drop rst_n after the 2nd RUN cycle → out_valid never rises, sum=0; a subsequent op of 0x0012+0x0005 yields sum=0x0017.
  - NIBBLES=1 build: op_a=12, op_b=5, op_cin=1 → sum=2, cout=1, out_valid one cycle after acceptance.
